// File: rtl/data_ram_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_resp_pkg
// Description : Shared definitions for the MEM-stage data-RAM responder:
//               FSM state encodings, byte-lane geometry, zero word and the
//               default wait-state count.
// Revision    : 1.0 - initial release
// ============================================================================
package data_ram_resp_pkg;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'd0,
    DRAM_WAIT = 2'd1,
    DRAM_RESP = 2'd2
  } dram_state_t;

  localparam logic [31:0] ZeroWord            = 32'h0000_0000;
  localparam int          BYTE_WIDTH          = 8;
  localparam int          NUM_LANES           = 4;
  localparam int          DEFAULT_WAIT_STATES = 1;

endpackage : data_ram_resp_pkg
`default_nettype wire

// File: rtl/data_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_array
// Description : Synchronous single-port 32-bit word array with four byte
//               write enables and a registered read port. The read register
//               is cleared by reset; the storage itself is not.
//               squash blocks a write and turns a read into a zero return.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_array
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [31:0]           wdata,
  input  logic                  squash,
  output logic [31:0]           rdata
);

  logic [31:0] r_mem [2**ADDR_WIDTH];

  // Byte-lane writes; only lanes with their enable bit set are touched.
  always_ff @(posedge clk) begin
    if (en && !squash) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (we[i]) begin
          r_mem[index][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Registered read port; holds its value until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= ZeroWord;
    end else if (en && (we == 4'b0000)) begin
      rdata <= squash ? ZeroWord : r_mem[index];
    end
  end

endmodule : data_ram_array
`default_nettype wire

// File: rtl/data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_resp
// Description : Responder end of the MEM-stage data-RAM interface. Accepts a
//               request, spends WAIT_STATES cycles in WAIT, performs the
//               byte-lane write or word read, then spends one cycle in RESP.
//               stallreq_o holds the pipeline for WAIT_STATES+1 cycles.
//               Optional macro DRAM_ADDR_CHECK_EN adds an address check that
//               raises err_o, blocks erroneous writes and zeroes bad reads.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic [3:0]  mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        err_o
);

  localparam logic [3:0] c_wait_states = 4'(WAIT_STATES);

  dram_state_t r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_we;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  logic        w_accept;
  logic        w_wait_done;
  logic        w_access;
  logic [3:0]  w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_squash;

  // A request is accepted in IDLE; with no wait states the access happens
  // on that same edge using the live inputs, otherwise the latched copy.
  assign w_accept    = (r_state == DRAM_IDLE) && mem_ce_i;
  assign w_wait_done = (r_state == DRAM_WAIT) && mem_ce_i && (r_cnt == 4'd1);
  assign w_access    = (w_accept && (c_wait_states == 4'd0)) || w_wait_done;

  assign w_we    = (r_state == DRAM_IDLE) ? mem_we_i   : r_we;
  assign w_addr  = (r_state == DRAM_IDLE) ? mem_addr_i : r_addr;
  assign w_wdata = (r_state == DRAM_IDLE) ? mem_data_i : r_data;

  assign stallreq_o = w_accept || (r_state == DRAM_WAIT);

  // Request FSM: latch in IDLE, count down in WAIT (flush on ce drop),
  // single RESP cycle back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DRAM_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 4'd0;
      r_addr  <= 32'd0;
      r_data  <= 32'd0;
    end else begin
      case (r_state)
        DRAM_IDLE: begin
          if (mem_ce_i) begin
            r_we    <= mem_we_i;
            r_addr  <= mem_addr_i;
            r_data  <= mem_data_i;
            r_cnt   <= c_wait_states;
            r_state <= (c_wait_states == 4'd0) ? DRAM_RESP : DRAM_WAIT;
          end
        end
        DRAM_WAIT: begin
          if (!mem_ce_i) begin
            r_cnt   <= 4'd0;
            r_state <= DRAM_IDLE;
          end else if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= DRAM_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DRAM_RESP: r_state <= DRAM_IDLE;
        default:   r_state <= DRAM_IDLE;
      endcase
    end
  end

`ifdef DRAM_ADDR_CHECK_EN
  logic w_err;
  logic r_err;

  // Out-of-range high bits, or a misaligned full-word write / word read.
  assign w_err = (|w_addr[31:ADDR_WIDTH+2]) ||
                 ((w_addr[1:0] != 2'b00) && ((w_we == 4'b1111) || (w_we == 4'b0000)));
  assign w_squash = w_err;

  // Error flag set by the access, cleared when a new request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_access) begin
      r_err <= w_err;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_addr;

  // High address bits alias and the byte offset is ignored.
  assign w_unused_addr = ^{w_addr[31:ADDR_WIDTH+2], w_addr[1:0]};
  assign w_squash      = 1'b0;
  assign err_o         = 1'b0;
`endif

  data_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .en     (w_access),
    .we     (w_we),
    .index  (w_addr[ADDR_WIDTH+1:2]),
    .wdata  (w_wdata),
    .squash (w_squash),
    .rdata  (mem_data_o)
  );

endmodule : data_ram_resp
`default_nettype wire

// File: tb/tb_data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_resp
// Description : Directed bench for data_ram_resp with three instances
//               (WAIT_STATES = 0, 1, 3). Index 0 -> WS0, 1 -> WS1, 2 -> WS3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_resp;

  logic        clk;
  logic        rst;
  logic        ce    [3];
  logic [3:0]  we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        err   [3];

  int n_checks;
  int n_fails;

  data_ram_resp #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we[0]), .mem_addr_i(addr[0]),
    .mem_data_i(wdata[0]), .mem_data_o(rdata[0]), .stallreq_o(stall[0]), .err_o(err[0]));

  data_ram_resp #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we[1]), .mem_addr_i(addr[1]),
    .mem_data_i(wdata[1]), .mem_data_o(rdata[1]), .stallreq_o(stall[1]), .err_o(err[1]));

  data_ram_resp #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .mem_ce_i(ce[2]), .mem_we_i(we[2]), .mem_addr_i(addr[2]),
    .mem_data_i(wdata[2]), .mem_data_o(rdata[2]), .stallreq_o(stall[2]), .err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Acts as the MEM stage: present a request, count stall cycles, and
  // capture read data in the RESP cycle, where ce is dropped.
  task automatic req(input int d, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] wd, output int stalls, output logic [31:0] rd);
    stalls = 0;
    @(negedge clk);
    ce[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    #1;
    while (stall[d] === 1'b1 && stalls < 64) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rd    = rdata[d];
    ce[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          s;
    logic [31:0] rd;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ce[i] = 1'b0; we[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end

    // Reset state
    #3;
    check_eq("rst_data", rdata[1], 32'h0);
    check_eq("rst_stall", {31'b0, stall[1]}, 32'd0);
    check_eq("rst_err", {31'b0, err[1]}, 32'd0);
    ce[1] = 1'b1;
    #1;
    check_eq("rst_stall_ce", {31'b0, stall[1]}, 32'd1);
    ce[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Word write then read, WAIT_STATES=1
    req(1, 4'b1111, 32'h10, 32'hDEADBEEF, s, rd);
    check_eq("ws1_wr_stalls", 32'(s), 32'd2);
    check_eq("ws1_wr_keeps_data", rd, 32'h0);
    req(1, 4'b0000, 32'h10, 32'h0, s, rd);
    check_eq("ws1_rd_stalls", 32'(s), 32'd2);
    check_eq("ws1_rd_data", rd, 32'hDEADBEEF);

    // Byte-lane write
    req(1, 4'b0100, 32'h10, 32'h00AA0000, s, rd);
    check_eq("lane_wr_hold", rd, 32'hDEADBEEF);
    req(1, 4'b0000, 32'h10, 32'h0, s, rd);
    check_eq("lane_rd_data", rd, 32'hDEAABEEF);

`ifndef DRAM_ADDR_CHECK_EN
    // Aliasing and ignored byte offset
    req(1, 4'b0000, 32'h0000_1010, 32'h0, s, rd);
    check_eq("alias_rd", rd, 32'hDEAABEEF);
    req(1, 4'b0000, 32'h13, 32'h0, s, rd);
    check_eq("offset_rd", rd, 32'hDEAABEEF);
`endif

    // Write leaves read data untouched
    req(1, 4'b1111, 32'h14, 32'h11223344, s, rd);
    check_eq("wr_hold_data", rd, 32'hDEAABEEF);

    // Flush during WAIT
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 4'b1111; addr[1] = 32'h10; wdata[1] = 32'h55555555;
    @(negedge clk);
    #1;
    check_eq("flush_in_wait", {31'b0, stall[1]}, 32'd1);
    ce[1] = 1'b0;
    @(negedge clk);
    #1;
    check_eq("flush_idle", {31'b0, stall[1]}, 32'd0);
    req(1, 4'b0000, 32'h10, 32'h0, s, rd);
    check_eq("flush_old_val", rd, 32'hDEAABEEF);

    // Asynchronous reset mid-WAIT
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 4'b1111; addr[1] = 32'h14; wdata[1] = 32'h99999999;
    @(negedge clk);
    #1;
    check_eq("arst_pre_stall", {31'b0, stall[1]}, 32'd1);
    #2;
    rst   = 1'b0;
    ce[1] = 1'b0;
    #1;
    check_eq("arst_data", rdata[1], 32'h0);
    check_eq("arst_stall", {31'b0, stall[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req(1, 4'b0000, 32'h14, 32'h0, s, rd);
    check_eq("arst_no_write", rd, 32'h11223344);
    req(1, 4'b0000, 32'h10, 32'h0, s, rd);
    check_eq("arst_intact", rd, 32'hDEAABEEF);

    // Read-after-write in consecutive requests
    req(1, 4'b1111, 32'h24, 32'h0BADF00D, s, rd);
    req(1, 4'b0000, 32'h24, 32'h0, s, rd);
    check_eq("raw_data", rd, 32'h0BADF00D);

    // WAIT_STATES=0
    req(0, 4'b1111, 32'h8, 32'h12345678, s, rd);
    check_eq("ws0_wr_stalls", 32'(s), 32'd1);
    req(0, 4'b0000, 32'h8, 32'h0, s, rd);
    check_eq("ws0_rd_stalls", 32'(s), 32'd1);
    check_eq("ws0_rd_data", rd, 32'h12345678);

    // WAIT_STATES=3
    req(2, 4'b1111, 32'hC, 32'hA5A5C3C3, s, rd);
    check_eq("ws3_wr_stalls", 32'(s), 32'd4);
    req(2, 4'b0000, 32'hC, 32'h0, s, rd);
    check_eq("ws3_rd_stalls", 32'(s), 32'd4);
    check_eq("ws3_rd_data", rd, 32'hA5A5C3C3);

`ifdef DRAM_ADDR_CHECK_EN
    // Address check
    req(1, 4'b0000, 32'h0000_1002, 32'h0, s, rd);
    check_eq("chk_err_set", {31'b0, err[1]}, 32'd1);
    check_eq("chk_err_data", rd, 32'h0);
    req(1, 4'b1111, 32'h0000_1010, 32'h77777777, s, rd);
    check_eq("chk_wr_err", {31'b0, err[1]}, 32'd1);
    req(1, 4'b0000, 32'h10, 32'h0, s, rd);
    check_eq("chk_err_clr", {31'b0, err[1]}, 32'd0);
    check_eq("chk_wr_blocked", rd, 32'hDEAABEEF);
`else
    check_eq("err_tied_low", {31'b0, err[1]}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule : tb_data_ram_resp
`default_nettype wire

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Responder end of the memory-stage data-RAM interface: accepts ce/we/addr/data requests from the MEM stage and performs byte-lane writes or word reads on an internal word array.
- Inserts a programmable number of wait states and holds the pipeline with stallreq_o until the access completes.
- Sits beside the MEM stage. Read data returns to MEM/WB; stallreq_o goes to the stall controller.

Parameters:
- ADDR_WIDTH, 10, word-address bits; the array holds 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles spent in WAIT before the array access (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- mem_ce_i  input  1  request valid; RAM enable from the MEM stage.
- mem_we_i  input  4  byte-lane write enables; bit n covers data[8n+7:8n]; 4'b0000 means read.
- mem_addr_i  input  32  byte address.
- mem_data_i  input  32  write data, already lane-aligned by the MEM stage.
- mem_data_o  output  32  read data, registered.
- stallreq_o  output  1  pipeline hold request, combinational from state and mem_ce_i.
- err_o  output  1  access error flag, registered; present only with DRAM_ADDR_CHECK_EN, otherwise tied 0.

Behaviour:
- Reset while rst=0, asynchronous, any state: state=IDLE, wait counter=0, mem_data_o=32'h0, err_o=0. stallreq_o evaluates to mem_ce_i (state is IDLE). Array contents are not reset. A reset arriving mid-access aborts the access; no partial write is performed.
- Word index = mem_addr_i[ADDR_WIDTH+1:2]. Bits [1:0] are ignored. Bits above ADDR_WIDTH+1 are ignored, so addresses alias/wrap modulo array size (unless the optional feature is enabled).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_ce_i=1: latch we/addr/data; counter=WAIT_STATES.
  - If WAIT_STATES=0, perform the access at this edge and go to RESP; otherwise go to WAIT.
  - mem_ce_i=0: stay in IDLE.
- WAIT:
  - counter>1: decrement.
  - counter==1: perform the access using the latched request; go to RESP.
  - mem_ce_i=0 at any edge in WAIT (pipeline flush): abort, no access, return to IDLE.
- Access:
  - Write (latched we!=0): only lanes with we bit=1 update. mem_data_o is unchanged.
  - Read (we==0): mem_data_o <= array[index].
- RESP: lasts exactly one cycle, then unconditionally goes to IDLE. The MEM stage advances at the edge ending RESP; a new request is seen in IDLE on the next cycle.
- stallreq_o = (state==IDLE && mem_ce_i) || state==WAIT. It is 0 in RESP.
- Stall cycles per access = WAIT_STATES+1.
- Back-to-back requests: minimum spacing is one IDLE cycle, so every request pays the full stall.
- mem_data_o holds its value until the next completed read.
- Read-after-write to the same word in consecutive requests returns the newly written bytes, because the write commits before RESP.

Optional Feature:
- DRAM_ADDR_CHECK_EN defined:
  - At access time, err_o <= 1 if latched addr[31:ADDR_WIDTH+2] != 0, or addr[1:0] != 0 while we is 4'b1111 or a word read.
  - On error, the write is suppressed and a read returns 32'h0.
  - err_o clears to 0 on the next accepted request.
- DRAM_ADDR_CHECK_EN undefined: no check logic, addresses alias, err_o constant 0.

Decomposition:
- Shared defines package: FSM state encodings (DRAM_IDLE/WAIT/RESP), ZeroWord, byte-lane width constants, the default for WAIT_STATES.
- One sub-module, data_ram_array: synchronous single-port word array with 4 byte write enables and a registered read port. The FSM drives it.

Test Plan:
- Word write then read, WAIT_STATES=1: write addr=0x10, we=4'b1111, data=0xDEADBEEF → stallreq_o high 2 cycles. Read addr=0x10 → mem_data_o=0xDEADBEEF in RESP, stallreq_o high 2 cycles.
- Byte lanes: with word 0x10=0xDEADBEEF, write we=4'b0100, data=0x00AA0000 → read returns 0xDEAABEEF.
- WAIT_STATES=0: read → stallreq_o high exactly 1 cycle, data valid in the following RESP cycle. WAIT_STATES=3 → 4 stall cycles.
- Flush: write issued, mem_ce_i dropped during WAIT → return to IDLE; a later read of that word shows the old value.
- Async reset: rst pulsed low mid-WAIT between clock edges → mem_data_o=0 and state IDLE immediately. The pending write is absent, and previously written words are intact.
- DRAM_ADDR_CHECK_EN: read addr=0x00001002 with ADDR_WIDTH=10 → err_o=1, mem_data_o=0. The next valid request clears err_o.
